// File: rtl/output_sr_sched.sv
// Write scheduler for an output shift register: round-robin arbitration of two
// requesters against reserved word occupancy, with a flush/drain/hold sequence.
module output_sr_sched #(
    parameter int DWIDTH = 16,
    parameter int DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  dbl0,
    input  logic                  dbl1,
    input  logic [2*DWIDTH-1:0]   din0,
    input  logic [2*DWIDTH-1:0]   din1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic [2*DWIDTH-1:0]   sr_data_in,
    output logic                  sr_wen_w1,
    output logic                  sr_wen_w2,
    input  logic                  sr_valid,
    output logic                  sr_ren,
    input  logic                  out_ready,
    input  logic                  flush,
    output logic                  flush_done,
    output logic [3:0]            occupancy,
    output logic [1:0]            o_state
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_FLUSH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t              r_state;
    logic [3:0]          r_occ;
    logic                r_last;
    logic [2*DWIDTH-1:0] r_data;
    logic                r_wen1;
    logic                r_wen2;
    logic                r_flush_done;

    logic [1:0] w_need0;
    logic [1:0] w_need1;
    logic       w_fit0;
    logic       w_fit1;
    logic       w_run_ok;
    logic       w_elig0;
    logic       w_elig1;
    logic       w_gnt0;
    logic       w_gnt1;
    logic       w_ren;
    logic [3:0] w_add;
    logic [3:0] w_occ_next;

    assign w_need0 = dbl0 ? 2'd2 : 2'd1;
    assign w_need1 = dbl1 ? 2'd2 : 2'd1;
    // Fit uses the registered count only; a pop in the same cycle is not credited.
    assign w_fit0  = ({1'b0, r_occ} + {3'b000, w_need0}) <= 5'(DEPTH);
    assign w_fit1  = ({1'b0, r_occ} + {3'b000, w_need1}) <= 5'(DEPTH);

    // No grant on the cycle RUN hands over to FLUSH.
    assign w_run_ok = reset & (r_state == S_RUN) & ~flush;
    assign w_elig0  = req0 & w_fit0 & w_run_ok;
    assign w_elig1  = req1 & w_fit1 & w_run_ok;
    // r_last = 1 means requester 1 was granted last, so requester 0 wins a tie.
    assign w_gnt0   = w_elig0 & (~w_elig1 | r_last);
    assign w_gnt1   = w_elig1 & (~w_elig0 | ~r_last);

    assign w_ren = reset & sr_valid & out_ready & (r_occ != 4'd0);

    always_comb begin
        w_add = 4'd0;
        if (w_gnt0) begin
            w_add = {2'b00, w_need0};
        end else if (w_gnt1) begin
            w_add = {2'b00, w_need1};
        end
    end

    assign w_occ_next = r_occ + w_add - {3'b000, w_ren};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_RUN;
            r_occ        <= 4'd0;
            r_last       <= 1'b1;
            r_data       <= '0;
            r_wen1       <= 1'b0;
            r_wen2       <= 1'b0;
            r_flush_done <= 1'b0;
        end else begin
            r_occ        <= w_occ_next;
            r_wen1       <= 1'b0;
            r_wen2       <= 1'b0;
            r_flush_done <= 1'b0;
            if (w_gnt0) begin
                r_last <= 1'b0;
                r_data <= din0;
                r_wen1 <= ~dbl0;
                r_wen2 <= dbl0;
            end else if (w_gnt1) begin
                r_last <= 1'b1;
                r_data <= din1;
                r_wen1 <= ~dbl1;
                r_wen2 <= dbl1;
            end
            case (r_state)
                S_RUN: begin
                    if (flush) begin
                        r_state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    // Drained only once nothing is reserved and no strobe is still in flight.
                    if ((r_occ == 4'd0) && !r_wen1 && !r_wen2) begin
                        r_state      <= S_HOLD;
                        r_flush_done <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!flush) begin
                        r_state <= S_RUN;
                    end
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

    assign gnt0       = w_gnt0;
    assign gnt1       = w_gnt1;
    assign sr_ren     = w_ren;
    assign sr_data_in = r_data;
    assign sr_wen_w1  = r_wen1;
    assign sr_wen_w2  = r_wen2;
    assign flush_done = r_flush_done;
    assign occupancy  = r_occ;
    assign o_state    = r_state;

endmodule

// File: tb/tb_output_sr_sched.sv
// Directed bench for output_sr_sched (DWIDTH=16, DEPTH=4): a vector table for the
// arbitration/occupancy path plus hand sequences for flush and reset-mid-flush.
module tb_output_sr_sched;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic        clk;
    logic        reset;
    logic        req0, req1, dbl0, dbl1;
    logic [31:0] din0, din1;
    logic        gnt0, gnt1;
    logic [31:0] sr_data_in;
    logic        sr_wen_w1, sr_wen_w2;
    logic        sr_valid, sr_ren, out_ready, flush, flush_done;
    logic [3:0]  occupancy;
    logic [1:0]  o_state;

    int n_checks;
    int n_errors;

    output_sr_sched #(.DWIDTH(16), .DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .dbl0(dbl0), .dbl1(dbl1),
        .din0(din0), .din1(din1),
        .gnt0(gnt0), .gnt1(gnt1),
        .sr_data_in(sr_data_in), .sr_wen_w1(sr_wen_w1), .sr_wen_w2(sr_wen_w2),
        .sr_valid(sr_valid), .sr_ren(sr_ren), .out_ready(out_ready),
        .flush(flush), .flush_done(flush_done),
        .occupancy(occupancy), .o_state(o_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        req0, req1, dbl0, dbl1;
        logic [31:0] din0, din1;
        logic        sv, ordy;
        logic        e_g0, e_g1, e_ren;
        logic [3:0]  e_occ;
        logic        e_w1, e_w2;
        logic [31:0] e_data;
    } vec_t;

    vec_t vt[14];

    function automatic vec_t mk(input logic r0, input logic r1, input logic d0, input logic d1,
                                input logic [31:0] x0, input logic [31:0] x1,
                                input logic sv, input logic ordy,
                                input logic g0, input logic g1, input logic ren,
                                input logic [3:0] occ, input logic w1, input logic w2,
                                input logic [31:0] data);
        vec_t v;
        v.req0 = r0; v.req1 = r1; v.dbl0 = d0; v.dbl1 = d1;
        v.din0 = x0; v.din1 = x1; v.sv = sv; v.ordy = ordy;
        v.e_g0 = g0; v.e_g1 = g1; v.e_ren = ren;
        v.e_occ = occ; v.e_w1 = w1; v.e_w2 = w2; v.e_data = data;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one vector, check the combinational outputs, then the registered ones after the edge.
    task automatic apply(input vec_t v, input string tag);
        req0 = v.req0; req1 = v.req1; dbl0 = v.dbl0; dbl1 = v.dbl1;
        din0 = v.din0; din1 = v.din1; sr_valid = v.sv; out_ready = v.ordy;
        #2;
        chk({tag, ".gnt0"}, {31'd0, gnt0}, {31'd0, v.e_g0});
        chk({tag, ".gnt1"}, {31'd0, gnt1}, {31'd0, v.e_g1});
        chk({tag, ".sr_ren"}, {31'd0, sr_ren}, {31'd0, v.e_ren});
        @(posedge clk);
        #2;
        chk({tag, ".occupancy"}, {28'd0, occupancy}, {28'd0, v.e_occ});
        chk({tag, ".sr_wen_w1"}, {31'd0, sr_wen_w1}, {31'd0, v.e_w1});
        chk({tag, ".sr_wen_w2"}, {31'd0, sr_wen_w2}, {31'd0, v.e_w2});
        chk({tag, ".sr_data_in"}, sr_data_in, v.e_data);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        //            r0 r1 d0 d1 din0          din1          sv or  g0 g1 ren occ w1 w2 data
        vt[0]  = mk(1, 0, 0, 0, 32'h0000ABCD, 32'h0,        0, 0,  1, 0, 0,  1, 1, 0, 32'h0000ABCD);
        vt[1]  = mk(1, 1, 0, 0, 32'h00002222, 32'h00001111, 1, 1,  0, 1, 1,  1, 1, 0, 32'h00001111);
        vt[2]  = mk(1, 1, 0, 0, 32'h00002222, 32'h00001111, 1, 1,  1, 0, 1,  1, 1, 0, 32'h00002222);
        vt[3]  = mk(1, 1, 0, 0, 32'h00002222, 32'h00001111, 1, 1,  0, 1, 1,  1, 1, 0, 32'h00001111);
        vt[4]  = mk(1, 1, 0, 0, 32'h00002222, 32'h00001111, 1, 1,  1, 0, 1,  1, 1, 0, 32'h00002222);
        vt[5]  = mk(0, 1, 0, 1, 32'h0,        32'hDEADBEEF, 0, 0,  0, 1, 0,  3, 0, 1, 32'hDEADBEEF);
        vt[6]  = mk(1, 1, 1, 0, 32'hCAFEF00D, 32'h00005555, 0, 0,  0, 1, 0,  4, 1, 0, 32'h00005555);
        vt[7]  = mk(1, 1, 1, 0, 32'hCAFEF00D, 32'h00005555, 0, 0,  0, 0, 0,  4, 0, 0, 32'h00005555);
        vt[8]  = mk(1, 0, 1, 0, 32'hCAFEF00D, 32'h0,        1, 1,  0, 0, 1,  3, 0, 0, 32'h00005555);
        vt[9]  = mk(1, 0, 1, 0, 32'hCAFEF00D, 32'h0,        1, 1,  0, 0, 1,  2, 0, 0, 32'h00005555);
        vt[10] = mk(1, 0, 1, 0, 32'hCAFEF00D, 32'h0,        1, 1,  1, 0, 1,  3, 0, 1, 32'hCAFEF00D);
        vt[11] = mk(0, 0, 0, 0, 32'h0,        32'h0,        1, 1,  0, 0, 1,  2, 0, 0, 32'hCAFEF00D);
        vt[12] = mk(0, 0, 0, 0, 32'h0,        32'h0,        0, 1,  0, 0, 0,  2, 0, 0, 32'hCAFEF00D);
        vt[13] = mk(0, 0, 0, 0, 32'h0,        32'h0,        1, 0,  0, 0, 0,  2, 0, 0, 32'hCAFEF00D);

        // Reset: outputs forced low even with live requests and a ready consumer.
        reset = 1'b0; flush = 1'b0;
        req0 = 1'b1; req1 = 1'b1; dbl0 = 1'b0; dbl1 = 1'b0;
        din0 = 32'h12345678; din1 = 32'h9ABCDEF0; sr_valid = 1'b1; out_ready = 1'b1;
        #12;
        chk("rst.gnt0", {31'd0, gnt0}, 32'd0);
        chk("rst.gnt1", {31'd0, gnt1}, 32'd0);
        chk("rst.sr_ren", {31'd0, sr_ren}, 32'd0);
        chk("rst.occupancy", {28'd0, occupancy}, 32'd0);
        chk("rst.sr_data_in", sr_data_in, 32'd0);
        chk("rst.wen", {30'd0, sr_wen_w1, sr_wen_w2}, 32'd0);
        chk("rst.flush_done", {31'd0, flush_done}, 32'd0);
        chk("rst.state", {30'd0, o_state}, {30'd0, ST_RUN});
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 14; i++) begin
            apply(vt[i], $sformatf("vec%0d", i));
        end

        // Flush: bring occupancy to 3, then drain with flush held high.
        apply(mk(0, 1, 0, 0, 32'h0, 32'h00000077, 0, 0, 0, 1, 0, 3, 1, 0, 32'h00000077), "fl_fill");
        flush = 1'b1; req0 = 1'b1; req1 = 1'b0; dbl0 = 1'b0; sr_valid = 1'b1; out_ready = 1'b1;
        #2;
        chk("fl_enter.gnt0", {31'd0, gnt0}, 32'd0);
        chk("fl_enter.sr_ren", {31'd0, sr_ren}, 32'd1);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #2;
            chk($sformatf("fl%0d.occupancy", k), {28'd0, occupancy}, (k < 3) ? 32'(3 - k) : 32'd0);
            chk($sformatf("fl%0d.flush_done", k), {31'd0, flush_done}, (k == 4) ? 32'd1 : 32'd0);
            chk($sformatf("fl%0d.state", k), {30'd0, o_state}, (k < 4) ? {30'd0, ST_FLUSH} : {30'd0, ST_HOLD});
            chk($sformatf("fl%0d.gnt0", k), {31'd0, gnt0}, 32'd0);
        end
        flush = 1'b0;
        #1;
        chk("hold_exit.gnt0", {31'd0, gnt0}, 32'd0);
        @(posedge clk);
        #2;
        chk("resume.state", {30'd0, o_state}, {30'd0, ST_RUN});
        chk("resume.gnt0", {31'd0, gnt0}, 32'd1);
        chk("resume.flush_done", {31'd0, flush_done}, 32'd0);

        // Reset mid-flush: two-word grant now, enter FLUSH with occupancy 2 and no drain.
        dbl0 = 1'b1; din0 = 32'hA5A5A5A5; sr_valid = 1'b0;
        @(posedge clk);
        #2;
        chk("rmf_fill.occupancy", {28'd0, occupancy}, 32'd2);
        flush = 1'b1; req0 = 1'b0;
        @(posedge clk);
        #2;
        chk("rmf.state", {30'd0, o_state}, {30'd0, ST_FLUSH});
        chk("rmf.occupancy", {28'd0, occupancy}, 32'd2);
        req0 = 1'b1; sr_valid = 1'b1; out_ready = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        chk("rmf_rst.occupancy", {28'd0, occupancy}, 32'd0);
        chk("rmf_rst.gnt0", {31'd0, gnt0}, 32'd0);
        chk("rmf_rst.sr_ren", {31'd0, sr_ren}, 32'd0);
        chk("rmf_rst.sr_data_in", sr_data_in, 32'd0);
        chk("rmf_rst.wen", {30'd0, sr_wen_w1, sr_wen_w2}, 32'd0);
        chk("rmf_rst.state", {30'd0, o_state}, {30'd0, ST_RUN});
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0; req0 = 1'b0; sr_valid = 1'b0;
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #2;
            chk($sformatf("rmf_post%0d.flush_done", k), {31'd0, flush_done}, 32'd0);
            chk($sformatf("rmf_post%0d.state", k), {30'd0, o_state}, {30'd0, ST_RUN});
        end
        req0 = 1'b1; dbl0 = 1'b0;
        #1;
        chk("rmf_post.gnt0", {31'd0, gnt0}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
